// File: rtl/fir_pkg.sv
// Shared constants, state encoding and checksum helper for the FIR filter and its coefficient loader.
package fir_pkg;

    localparam int FIR_TAPS  = 5;
    localparam int FIR_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } fir_state_e;

    // Passthrough set: c1 = 1, every other tap 0.
    localparam logic [FIR_TAPS*FIR_WIDTH-1:0] FIR_PASSTHRU =
        {{(FIR_TAPS*FIR_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [FIR_WIDTH-1:0] fir_xor_fold(input logic [FIR_TAPS*FIR_WIDTH-1:0] v);
        logic [FIR_WIDTH-1:0] acc;
        acc = {FIR_WIDTH{1'b0}};
        for (int k = 0; k < FIR_TAPS; k++) begin
            acc = acc ^ v[k*FIR_WIDTH +: FIR_WIDTH];
        end
        return acc;
    endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Coefficient load stream: valid/ready word transfer plus an abort line.
interface fir_coeff_loader_if
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             load_abort;

    modport master (output load_valid, output load_data, output load_abort, input load_ready);
    modport slave  (input load_valid, input load_data, input load_abort, output load_ready);
endinterface

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient register pair; the active set is replaced wholesale on a commit strobe.
// With COEFF_CHECKSUM_EN defined the shadow set is exported for checksum verification.
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int TAPS  = FIR_TAPS,
    parameter int WIDTH = FIR_WIDTH,
    parameter int IDXW  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [IDXW-1:0]       i_wr_idx,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_commit,
`ifdef COEFF_CHECKSUM_EN
    output logic [TAPS*WIDTH-1:0] o_shadow,
`endif
    output logic [TAPS*WIDTH-1:0] o_active
);
    localparam logic [TAPS*WIDTH-1:0] RST_SET = {{(TAPS*WIDTH-1){1'b0}}, 1'b1};

    logic [TAPS*WIDTH-1:0] r_shadow;
    logic [TAPS*WIDTH-1:0] r_active;

    // Shadow writes by index and atomic shadow-to-active copy
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow <= {(TAPS*WIDTH){1'b0}};
            r_active <= RST_SET;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (i_wr_en && (i_wr_idx == IDXW'(k))) begin
                    r_shadow[k*WIDTH +: WIDTH] <= i_wr_data;
                end
            end
            if (i_commit) begin
                r_active <= r_shadow;
            end
        end
    end

    assign o_active = r_active;
`ifdef COEFF_CHECKSUM_EN
    assign o_shadow = r_shadow;
`endif

endmodule

// File: rtl/fir_coeff_loader.sv
// Run-time writer of the FIR tap set: buffers TAPS words, then commits them in one cycle.
// COEFF_CHECKSUM_EN adds a trailing XOR check word and the checksum_error pulse.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int TAPS  = FIR_TAPS,
    parameter int WIDTH = FIR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    fir_coeff_loader_if.slave     load_if,
    output logic [TAPS*WIDTH-1:0] coeffs,
    output logic                  coeff_update,
`ifdef COEFF_CHECKSUM_EN
    output logic                  checksum_error,
`endif
    output logic                  busy
);
    localparam int IDXW = $clog2(TAPS + 1);

    fir_state_e      r_state;
    fir_state_e      w_state_nxt;
    logic [IDXW-1:0] r_index;
    logic [IDXW-1:0] w_index_nxt;
    logic            r_ready;
    logic            r_busy;
    logic            r_update;
    logic            r_cksum_err;
    logic            w_accept;
    logic            w_wr_en;
    logic            w_commit;
    logic            w_cksum_err;
`ifdef COEFF_CHECKSUM_EN
    logic [TAPS*WIDTH-1:0] w_shadow;
`endif

    fir_coeff_bank #(.TAPS(TAPS), .WIDTH(WIDTH), .IDXW(IDXW)) u_bank (
        .clock     (clock),
        .reset     (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_index),
        .i_wr_data (load_if.load_data),
        .i_commit  (w_commit),
`ifdef COEFF_CHECKSUM_EN
        .o_shadow  (w_shadow),
`endif
        .o_active  (coeffs)
    );

    // Next-state, shadow write and commit decode; abort beats a simultaneous word
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_wr_en     = 1'b0;
        w_commit    = 1'b0;
        w_cksum_err = 1'b0;
        w_accept    = load_if.load_valid & r_ready & ~load_if.load_abort;
        case (r_state)
            IDLE, LOAD: begin
                if (load_if.load_abort) begin
                    w_state_nxt = IDLE;
                    w_index_nxt = {IDXW{1'b0}};
                end else if (w_accept) begin
                    w_wr_en = 1'b1;
                    if (r_index == IDXW'(TAPS - 1)) begin
                        w_index_nxt = {IDXW{1'b0}};
`ifdef COEFF_CHECKSUM_EN
                        w_state_nxt = CHECK;
`else
                        w_state_nxt = COMMIT;
`endif
                    end else begin
                        w_index_nxt = r_index + IDXW'(1);
                        w_state_nxt = LOAD;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            CHECK: begin
`ifdef COEFF_CHECKSUM_EN
                if (load_if.load_abort) begin
                    w_state_nxt = IDLE;
                end else if (w_accept) begin
                    if (load_if.load_data == fir_xor_fold(w_shadow)) begin
                        w_state_nxt = COMMIT;
                    end else begin
                        w_state_nxt = IDLE;
                        w_cksum_err = 1'b1;
                    end
                end else begin
                    w_state_nxt = CHECK;
                end
`else
                w_state_nxt = IDLE;
`endif
                w_index_nxt = {IDXW{1'b0}};
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
                w_index_nxt = {IDXW{1'b0}};
            end
            default: begin
                w_state_nxt = IDLE;
                w_index_nxt = {IDXW{1'b0}};
            end
        endcase
    end

    // State and registered handshake/status outputs, derived from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_index     <= {IDXW{1'b0}};
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_update    <= 1'b0;
            r_cksum_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_index     <= w_index_nxt;
            r_ready     <= (w_state_nxt != COMMIT);
            r_busy      <= (w_index_nxt != {IDXW{1'b0}}) || (w_state_nxt == COMMIT) ||
                           (w_state_nxt == CHECK);
            r_update    <= w_commit;
            r_cksum_err <= w_cksum_err;
        end
    end

    assign load_if.load_ready = r_ready;
    assign coeff_update       = r_update;
    assign busy               = r_busy;
`ifdef COEFF_CHECKSUM_EN
    assign checksum_error     = r_cksum_err;
`endif

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Programs the 5-tap FIR filter's coefficients at run time. It is the writer side of the coefficient interface that the filter reads.
- Accepts coefficients one word at a time over a valid/ready stream and buffers them in shadow registers.
- Commits all taps atomically in a single cycle, so the filter never convolves with a mixed old/new coefficient set.
- Sits between the control/config path and the filter's c1..c5 inputs.

Parameters:
- TAPS, 5, number of coefficients (c1..cTAPS).
- WIDTH, 16, signed coefficient width in bits.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  load_data holds a coefficient word.
- load_data  input  WIDTH  signed coefficient word. Sent in order c1 first, cTAPS last.
- load_ready  output  1  loader can accept a word this cycle.
- load_abort  input  1  discard the partially loaded set.
- coeffs  output  TAPS*WIDTH  active coefficients. Tap k (k=0 is c1) sits at [k*WIDTH +: WIDTH].
- coeff_update  output  1  one-cycle pulse in the cycle after a commit.
- busy  output  1  a load is in progress (index != 0) or in COMMIT.

Behaviour:
- Reset is synchronous and active-high; all outputs are registered. On reset:
  - coeffs = passthrough set: c1 = 1, all other taps = 0.
  - coeff_update = 0, busy = 0, load_ready = 1.
  - State = IDLE, index = 0, shadow registers cleared.
- A word is accepted only on a rising edge where load_valid & load_ready.
- States:
  - IDLE: index = 0, load_ready = 1. An accept stores the word into shadow[0], sets index = 1 and moves to LOAD (TAPS=1: straight to COMMIT).
  - LOAD: load_ready = 1. An accept stores the word into shadow[index] and increments index. The accept of shadow[TAPS-1] moves to COMMIT.
  - COMMIT: lasts exactly one cycle with load_ready = 0. On the next edge: coeffs <= shadow, coeff_update = 1 for one cycle, index = 0, back to IDLE.
- Latency: the last word is accepted at edge N; coeffs change and coeff_update rises at edge N+1. load_ready is high again after edge N+1.
- Stall: load_valid low in LOAD holds state indefinitely; there is no timeout.
- load_abort:
  - In IDLE or LOAD: index = 0, state = IDLE. coeffs unchanged, no coeff_update.
  - Abort together with load_valid: abort wins and the word is dropped.
  - In COMMIT: ignored; the commit completes.
- Reset mid-load or in COMMIT: shadow discarded and coeffs return to the passthrough set.
- load_data is stored unmodified; no saturation or scaling.

Optional Feature:
- Macro COEFF_CHECKSUM_EN.
- Defined:
  - After TAPS coefficients, one extra word is accepted: the 16-bit XOR of all TAPS words (state CHECK, between LOAD and COMMIT).
  - Match: commit as normal.
  - Mismatch: shadow discarded, coeffs unchanged, no coeff_update, and a one-cycle output pulse checksum_error (1 bit, reset 0) in the cycle after the check word is accepted. Return to IDLE.
  - load_abort in CHECK behaves as in LOAD.
- Undefined: the checksum_error port does not exist; commit follows the TAPS-th word directly.

Decomposition:
- Package fir_pkg holds:
  - FIR_TAPS = 5, FIR_WIDTH = 16.
  - The state enum (IDLE, LOAD, CHECK, COMMIT).
  - The passthrough reset coefficient constant.
- The filter reuses the same package constants.
- One sub-module, fir_coeff_bank: the shadow plus active register pair with write-enable/index and commit strobe. The FSM and handshake stay in fir_coeff_loader.

Test Plan:
- Reset, then idle -> coeffs = {c1=1, c2..c5=0}, load_ready=1, busy=0, coeff_update=0.
- Back-to-back words 3, -2, 7, 0, 5 -> after the 5th accept, one cycle with load_ready=0; then coeffs = {3,-2,7,0,5}, coeff_update high exactly one cycle, busy=0.
- Load 1, 2, then load_valid low for 10 cycles, then 3, 4, 5 -> coeffs unchanged until commit, then {1,2,3,4,5}.
- Load 9, 9, then load_abort asserted with load_valid and data 9 -> coeffs unchanged, no coeff_update, index 0. A following load of 1, 1, 1, 1, 1 commits {1,1,1,1,1}.
- Reset asserted after 3 of 5 words -> coeffs = passthrough, state IDLE. A fresh 5-word load commits correctly.
- COEFF_CHECKSUM_EN defined:
  - Words 1, 2, 3, 4, 5 then checksum 1 (1^2^3^4^5) -> commits {1,2,3,4,5}.
  - Same words with checksum 0 -> checksum_error pulses, coeffs unchanged.
